// File: rtl/rom_rr_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one synchronous ROM between N_REQ requesters.
// Grants one read per cycle and routes each returned word back to its issuer.
module rom_rr_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 128,
  parameter int ROM_LATENCY = 1,
  localparam int AW         = $clog2(DEPTH),
  localparam int PW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*AW-1:0]   i_addr,
  output logic [N_REQ-1:0]      o_gnt,
  output logic [N_REQ-1:0]      o_rvalid,
  output logic [WIDTH-1:0]      o_rdata,
  output logic [AW-1:0]         o_rom_addr,
  input  logic [WIDTH-1:0]      i_rom_dout
);

  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          win;
  logic                   any_gnt;
  logic [ROM_LATENCY-1:0] vld_q;
  logic [PW-1:0]          id_q [ROM_LATENCY];

  // Scan from the pointer with wrap-around; the first active request wins.
  always_comb begin
    win     = '0;
    any_gnt = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any_gnt && i_req[(int'(ptr_q) + i) % N_REQ]) begin
        any_gnt = 1'b1;
        win     = PW'((int'(ptr_q) + i) % N_REQ);
      end
    end
    if (i_rst) any_gnt = 1'b0;
  end

  always_comb begin
    o_gnt = '0;
    if (any_gnt) o_gnt[win] = 1'b1;
  end

  assign o_rom_addr = any_gnt ? i_addr[int'(win)*AW +: AW] : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt) ptr_d = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
  end

  // Valid bits are control and get cleared by reset so in-flight reads vanish.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
      vld_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      vld_q[0] <= any_gnt;
      for (int k = 1; k < ROM_LATENCY; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  always_ff @(posedge i_clk) begin
    id_q[0] <= win;
    for (int k = 1; k < ROM_LATENCY; k++) id_q[k] <= id_q[k-1];
  end

  always_comb begin
    o_rvalid = '0;
    if (vld_q[ROM_LATENCY-1]) o_rvalid[id_q[ROM_LATENCY-1]] = 1'b1;
  end

  assign o_rdata = i_rom_dout;

endmodule

// File: doc/rom_rr_arbiter.md
Name: rom_rr_arbiter

Overview:
Round-robin arbiter that shares one synchronous single-port ROM (registered output, fixed read latency) between N requesters. It grants at most one read per cycle and drives the ROM address. It tracks in-flight reads in a latency-matched pipeline and returns each data word to the requester that issued it. It sits between the font/lookup ROM instance and the consumer blocks (e.g. text renderer, sprite fetcher) that would otherwise each need their own ROM copy.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, ROM data width
DEPTH, 128, ROM depth; AW = $clog2(DEPTH)
ROM_LATENCY, 1, clock cycles from ROM address capture to valid data (1..4)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  asynchronous, active-high reset
i_req  in  N_REQ  per-requester read request; held with address until granted
i_addr  in  N_REQ*AW  packed addresses; requester k at bits [k*AW +: AW]
o_gnt  out  N_REQ  one-hot/zero combinational grant; request accepted at the clock edge where req&gnt
o_rvalid  out  N_REQ  one-hot/zero, registered; data for requester k on o_rdata this cycle
o_rdata  out  WIDTH  returned ROM word (i_rom_dout passthrough); meaningful only when |o_rvalid
o_rom_addr  out  AW  address to ROM i_rd_addr
i_rom_dout  in  WIDTH  ROM o_dout

Behaviour:
- Reset (async assert): rr pointer p=0, valid/id pipeline cleared, o_rvalid=0. o_gnt is forced to 0 while i_rst=1. o_rom_addr=0.
- Arbitration (combinational): scan requesters in order p, p+1, ..., wrapping mod N_REQ. The first with i_req=1 wins. o_gnt[win]=1, all others 0. No request gives o_gnt=0.
- o_rom_addr = i_addr of the winner; 0 when there is no grant.
- Pointer update on each edge with a grant: p <= (win+1) mod N_REQ. With no grant, p is unchanged.
- Throughput: one grant per cycle, back-to-back, with no bubbles. A requester holding i_req high continuously is granted at most once every N_REQ cycles while all N_REQ requesters are requesting.
- Requester protocol: i_req and its address must stay stable until the edge where o_gnt is seen. The requester may deassert or issue a new address in the following cycle. Deasserting i_req before grant is allowed; the request is simply dropped.
- Return pipeline: ROM_LATENCY-stage shift register of {valid, id}. Stage 0 is loaded at the grant edge. o_rvalid = onehot(id) of the last stage when its valid bit is set.
- Latency: grant edge at cycle t gives o_rvalid[win]=1 and o_rdata=mem[addr] during cycle t+ROM_LATENCY. Exactly one o_rvalid pulse per grant, in grant order.
- A requester may have up to ROM_LATENCY reads in flight; responses arrive in order.
- Simultaneous grant and return in the same cycle is normal pipelined operation and needs no special handling.
- Reset mid-operation: all in-flight reads are discarded, with no o_rvalid after reset. The ROM itself is not reset; its stale output is ignored because o_rvalid=0.
- N_REQ=1 degenerates to pass-through: gnt=req, p stays 0.

Test Plan:
- N_REQ=4, ROM_LATENCY=1, ROM preloaded mem[a]=a^8'h5A. Requester 2 reads addr 7x10 -> gnt[2] same cycle; next cycle o_rvalid=4'b0100, o_rdata=8'h5D.
- All 4 requesters held high with addrs 1,2,3,4 from reset -> grants 0,1,2,3,0,... one per cycle; rvalid sequence 0001,0010,0100,1000 with data 5B,58,59,5E.
- p=2 (after granting 1); reqs 0 and 3 assert together -> 3 granted first, then 0; p ends at 1.
- ROM_LATENCY=3, requester 1 issues addrs 0,1,2 back-to-back -> rvalid[1] high on cycles t+3..t+5 with data 5A,5B,58.
- Assert i_rst one cycle after two grants in flight (ROM_LATENCY=3) -> o_rvalid never pulses for them; o_gnt=0 during reset; first post-reset grant goes to lowest requesting index.
- Random traffic for 10k cycles, scoreboard per requester -> every grant yields exactly one correct, in-order response; no requester waits more than N_REQ-1 cycles while requesting.
